// File: rtl/hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller: result-source
// and forward-select codes, per-stage shadow records and Tnew lookups.
package hazard_ctrl_pkg;

  typedef enum logic [2:0] {
    RES_NW  = 3'd0,
    RES_ALU = 3'd1,
    RES_DM  = 3'd2,
    RES_PC  = 3'd3
  } res_e;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_E    = 2'd1,
    FWD_M    = 2'd2,
    FWD_W    = 2'd3
  } fwd_code_e;

  typedef struct packed {
    logic [4:0] ra1;
    logic [4:0] ra2;
    logic [4:0] wa;
    res_e       res;
    logic       md_start;
    logic       md_div;
  } e_stage_t;

  typedef struct packed {
    logic [4:0] ra2;
    logic [4:0] wa;
    res_e       res;
  } m_stage_t;

  typedef struct packed {
    logic [4:0] wa;
    res_e       res;
  } w_stage_t;

  function automatic logic [1:0] tnew_e(input res_e res);
    case (res)
      RES_ALU: return 2'd1;
      RES_DM:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] tnew_m(input res_e res);
    return (res == RES_DM) ? 2'd1 : 2'd0;
  endfunction

  // True when a D operand needed at `tuse` would read a value not yet produced.
  function automatic logic op_hazard(input logic [4:0] addr, input logic [1:0] tuse,
                                     input logic [4:0] e_wa, input res_e e_res,
                                     input logic [4:0] m_wa, input res_e m_res);
    logic e_hit;
    logic m_hit;
    e_hit = (addr == e_wa) && (e_res != RES_NW) && (tnew_e(e_res) > tuse);
    m_hit = (addr == m_wa) && (m_res != RES_NW) && (tnew_m(m_res) > tuse);
    return (addr != 5'd0) && (e_hit || m_hit);
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Priority forward selector: picks the youngest ready stage whose destination
// matches the operand address; register 0 is never forwarded.
module hazard_ctrl_fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] addr,
  input  logic [4:0] e_wa,
  input  logic       e_rdy,
  input  logic [4:0] m_wa,
  input  logic       m_rdy,
  input  logic [4:0] w_wa,
  input  logic       w_rdy,
  output logic [1:0] sel
);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    sel = FWD_NONE;
    if (addr != 5'd0) begin
      if (e_rdy && (e_wa == addr))      sel = FWD_E;
      else if (m_rdy && (m_wa == addr)) sel = FWD_M;
      else if (w_rdy && (w_wa == addr)) sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage MIPS hazard controller: E/M/W shadow registers, D-stage stall,
// forwarding selects for D/E/M and the mult/div busy counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_ra1,
  input  logic [4:0] d_ra2,
  input  logic [4:0] d_wa,
  input  logic       d_tuse_rs0,
  input  logic       d_tuse_rs1,
  input  logic       d_tuse_rt0,
  input  logic       d_tuse_rt1,
  input  logic       d_tuse_rt2,
  input  logic [2:0] d_res,
  input  logic       d_md_start,
  input  logic       d_md_div,
  input  logic       d_md_use,
  output logic       stall,
  output logic [1:0] fwd_d_rs,
  output logic [1:0] fwd_d_rt,
  output logic [1:0] fwd_e_rs,
  output logic [1:0] fwd_e_rt,
  output logic [1:0] fwd_m_rt
);

  localparam int CNT_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  e_stage_t         e_q, e_d;
  m_stage_t         m_q, m_d;
  w_stage_t         w_q, w_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       rs_need, rt_need;
  logic [1:0] rs_tuse, rt_tuse;
  logic       reg_stall, md_stall;
  logic       e_rdy, m_rdy, w_rdy;

  always_comb begin
    rs_need = d_tuse_rs0 | d_tuse_rs1;
    rt_need = d_tuse_rt0 | d_tuse_rt1 | d_tuse_rt2;
    // The earliest stage that needs the operand is the one that can stall.
    rs_tuse = d_tuse_rs0 ? 2'd0 : 2'd1;
    rt_tuse = d_tuse_rt0 ? 2'd0 : (d_tuse_rt1 ? 2'd1 : 2'd2);

    reg_stall = (rs_need && op_hazard(d_ra1, rs_tuse, e_q.wa, e_q.res, m_q.wa, m_q.res)) ||
                (rt_need && op_hazard(d_ra2, rt_tuse, e_q.wa, e_q.res, m_q.wa, m_q.res));
    md_stall  = d_md_use && (e_q.md_start || (cnt_q != '0));
    stall     = reg_stall | md_stall;

    e_rdy = (e_q.res == RES_PC);
    m_rdy = (m_q.res == RES_ALU) || (m_q.res == RES_PC);
    w_rdy = (w_q.res != RES_NW);
  end

  always_comb begin
    w_d = '{wa: m_q.wa, res: m_q.res};
    m_d = '{ra2: e_q.ra2, wa: e_q.wa, res: e_q.res};
    e_d = '0;
    if (!stall) begin
      e_d = '{ra1: d_ra1, ra2: d_ra2, wa: d_wa, res: res_e'(d_res),
              md_start: d_md_start, md_div: d_md_div};
    end

    // A new start cannot reach E while busy, so load never competes with a live count.
    cnt_d = cnt_q;
    if (e_q.md_start) begin
      cnt_d = e_q.md_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q   <= '0;
      m_q   <= '0;
      w_q   <= '0;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      m_q   <= m_d;
      w_q   <= w_d;
      cnt_q <= cnt_d;
    end
  end

  hazard_ctrl_fwd_sel u_fwd_d_rs (
    .addr(d_ra1), .e_wa(e_q.wa), .e_rdy(e_rdy), .m_wa(m_q.wa), .m_rdy(m_rdy),
    .w_wa(w_q.wa), .w_rdy(w_rdy), .sel(fwd_d_rs)
  );

  hazard_ctrl_fwd_sel u_fwd_d_rt (
    .addr(d_ra2), .e_wa(e_q.wa), .e_rdy(e_rdy), .m_wa(m_q.wa), .m_rdy(m_rdy),
    .w_wa(w_q.wa), .w_rdy(w_rdy), .sel(fwd_d_rt)
  );

  hazard_ctrl_fwd_sel u_fwd_e_rs (
    .addr(e_q.ra1), .e_wa(5'd0), .e_rdy(1'b0), .m_wa(m_q.wa), .m_rdy(m_rdy),
    .w_wa(w_q.wa), .w_rdy(w_rdy), .sel(fwd_e_rs)
  );

  hazard_ctrl_fwd_sel u_fwd_e_rt (
    .addr(e_q.ra2), .e_wa(5'd0), .e_rdy(1'b0), .m_wa(m_q.wa), .m_rdy(m_rdy),
    .w_wa(w_q.wa), .w_rdy(w_rdy), .sel(fwd_e_rt)
  );

  hazard_ctrl_fwd_sel u_fwd_m_rt (
    .addr(m_q.ra2), .e_wa(5'd0), .e_rdy(1'b0), .m_wa(5'd0), .m_rdy(1'b0),
    .w_wa(w_q.wa), .w_rdy(w_rdy), .sel(fwd_m_rt)
  );

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core. It consumes the per-instruction decode products from the D stage: register addresses, Tuse class flags, result-source code, and mult/div class. It tracks those products through its own E/M/W shadow registers and produces the D-stage stall and every forwarding-mux select for the D, E and M stages. It also owns the mult/div busy counter that gates HI/LO accesses.

## Interface
Parameters:
- MULT_CYC, 5, busy cycles after a mult/multu leaves E
- DIV_CYC, 10, busy cycles after a div/divu leaves E

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high; clears all state
- d_ra1, d_ra2, d_wa  in  5 each  D-stage rs, rt, destination
- d_tuse_rs0, d_tuse_rs1  in  1 each  rs is needed in D (Tuse 0) / in E (Tuse 1)
- d_tuse_rt0, d_tuse_rt1, d_tuse_rt2  in  1 each  rt is needed in D / E / M (Tuse 0/1/2)
- d_res  in  3  result source: nw / alu / dm / pc
- d_md_start  in  1  D holds mult, multu, div or divu
- d_md_div  in  1  qualifies d_md_start: div or divu
- d_md_use  in  1  D holds mfhi, mflo, mthi, mtlo or a md start
- stall  out  1  freeze PC and IF/ID, insert bubble into ID/EX
- fwd_d_rs, fwd_d_rt  out  2  D comparator operand select
- fwd_e_rs, fwd_e_rt  out  2  E ALU operand select
- fwd_m_rt  out  2  M store-data select

## Operation
- Shadow registers:
  - E{ra1, ra2, wa, res, md_start, md_div}
  - M{ra2, wa, res}
  - W{wa, res}
- Every edge, W←M and M←E. E←D, unless stall=1, in which case E←bubble (wa=0, res=nw, md_start=0).
- Tnew:
  - E: alu→1, dm→2, pc→0
  - M: dm→1, otherwise 0
  - W: 0
  - nw never creates a hazard.
- Register stall condition: for each D operand with a Tuse flag set, stall if all of the following hold:
  - The operand address is nonzero.
  - It matches E.wa with Tnew_E > Tuse, or M.wa with Tnew_M > Tuse.
  - The matching stage's res is not nw.
  - If several Tuse flags are set on the same operand, the smallest Tuse governs.
- md stall: d_md_use && (E.md_start || busy).
- stall = register stall OR md stall.
- Forward select codes: 0 = no forwarding (own pipeline value), 1 = from E, 2 = from M, 3 = from W.
- Forward sources:
  - E may supply only if res=pc.
  - M may supply if res is alu or pc.
  - W may supply if res≠nw.
  - Address match is required and address 0 is never forwarded.
  - When several sources qualify, the youngest wins (E > M > W).
- fwd_d_* considers E/M/W. fwd_e_* uses E.ra1/E.ra2 against M/W. fwd_m_rt uses M.ra2 against W.
- Busy counter:
  - On an edge where E.md_start=1, load MULT_CYC or DIV_CYC (chosen by E.md_div).
  - Otherwise decrement while nonzero.
  - busy = counter≠0.

## Timing
- All selects and stall are combinational from the current shadow state plus D inputs. They are valid in the same cycle and contain no internal state.
- Reset (asynchronous) forces:
  - All shadow registers: wa=0, res=nw, md flags 0
  - Counter = 0
  - Outputs: stall=0, all fwd_*=0, regardless of D inputs
- Reset during busy aborts the operation and stall drops immediately.
- Stall latency:
  - alu→Tuse0: 1 cycle
  - dm→Tuse0: 2 cycles
  - dm→Tuse1: 1 cycle
  - dm→Tuse2: 0 cycles
- md total stall for an immediately following HI/LO access: 1 + DIV_CYC (11) after div; 1 + MULT_CYC (6) after mult.
- A second md start during busy is itself stalled, so there is no overlapping load.
- A simultaneous counter load and decrement cannot occur; the load has priority.

## Structure
- Shared header head.v holds:
  - res codes nw=0, alu=1, dm=2, pc=3
  - Forward codes NONE=0, FE=1, FM=2, FW=3
- One sub-module, fwd_sel, is natural: a priority forward selector (address, three stage {wa, ready} pairs → 2-bit code). Instantiate it five times.
- The busy counter stays inline.

## Test plan
- addu $3 in D, then beq $3,$0 → stall=1 for exactly 1 cycle; next cycle fwd_d_rs=2.
- lw $4, then addu $5,$4,$6 → stall 1 cycle; when addu is in E with lw in W, fwd_e_rs=3.
- lw $5, then sw $5,0($2) → stall never asserts; when sw is in M, fwd_m_rt=3.
- jal, then jr $31 → stall=0; fwd_d_rs=1 while jal is in E.
- div, then mflo → stall high 11 consecutive cycles. mult, then mfhi → 6 cycles. Assert reset on cycle 4 of div busy → stall=0 at once; counter reads 0 after reset.
- addu $0,$1,$2, then beq $0,$0 → stall=0, all fwd_*=0.
